bk_add_arbiter: RTL and testbench
=================================

Name: bk_add_arbiter

Overview:
- Shares one 32-bit Brent_Kung adder between NREQ requesters.
- Round-robin arbitration, valid/ready request ports, and a 2-stage pipeline:
  - Stage 1: operand register feeding the adder.
  - Stage 2: result register.
- Sits between client engines and the adder datapath.
- Sustains one add per cycle when the response side keeps rsp_ready high.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand width; must equal the Brent_Kung width.
- IDW, $clog2(NREQ), requester-id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*W  operand A, requester k at [k*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- req_last  in  NREQ  last beat of a chained add; used only with the optional feature
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_sum  out  W  sum
- rsp_cout  out  1  carry-out
- rsp_id  out  IDW  requester index of the result

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0. s1_valid=0, priority pointer=0, chain carry=0, FSM=ARB. req_ready is all zero while rst_n=0.
- Pipeline control:
  - adv2 = !rsp_valid || rsp_ready.
  - adv1 = !s1_valid || adv2.
  - A request is accepted only when adv1=1.
- Arbitration: among asserted req_valid, grant the first index at or after ptr, searching upward and wrapping NREQ-1 -> 0. req_ready[g]=adv1 for the granted g only. Arbitration is combinational in the same cycle.
- On accept:
  - Stage 1 captures a, b, cin, id, last.
  - ptr <= g+1 mod NREQ, wrapping.
  - With no valid requests, ptr holds.
- Stage 1 drives Brent_Kung combinationally. When adv2=1, stage 2 captures {cout, sum, id} and rsp_valid <= s1_valid.
- Latency: accept at edge N gives rsp_valid=1 after edge N+1, i.e. 2 cycles from the cycle req_valid&req_ready is sampled. Throughput is 1 per cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - rsp_* holds stable.
  - Stage 1 holds.
  - req_ready=0 once stage 1 is full.
- Simultaneous drain and fill is allowed in the same cycle with no bubble.
- Response: rsp_sum/rsp_cout equal (a+b+cin) truncated to W+1 bits: {rsp_cout,rsp_sum}.
- Requesters must hold operands while req_valid=1 and req_ready=0. Dropping req_valid before the grant is legal; that request is simply not served.
- Reset mid-operation: in-flight beats are discarded with no response, and the block returns to reset state immediately.
- FSM (meaningful only with the optional feature; otherwise permanently ARB):
  - ARB: normal arbitration. On accept with last=0, go to LOCKED(owner=g).
  - LOCKED: only the owner can be granted; other requesters see req_ready=0. On accepting an owner beat with last=1, return to ARB.
  - ptr advances only on the beat that returns to ARB.

Optional Feature:
BK_ADD_LOCK_EN:
- Defined: multi-word chained addition.
  - While LOCKED, the beat entering stage 1 uses the chain carry instead of req_cin.
  - The chain carry is the registered Brent_Kung cout of the previous owner beat, captured when that beat leaves stage 1.
  - The first beat of a chain uses req_cin.
- Undefined:
  - req_last is ignored and treated as 1.
  - The FSM and chain-carry register are not built.
  - Every beat uses req_cin.

Decomposition:
- Package bk_add_pkg: default W/NREQ constants, state enum {ARB, LOCKED}, the req_id type, and a helper for the operand slice.
- Sub-module rr_pick (round-robin first-set-from-pointer, pure combinational, NREQ-parameterised).
- The adder itself is an instance of the existing Brent_Kung (a, b, cin, s, cout).

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'hF → req_ready=0, rsp_valid=0, rsp_sum=0. Release → grant 0 on the first cycle.
- Single add: requester 1, a=FFFFFFFF, b=00000001, cin=0 → 2 cycles later rsp_valid=1, rsp_sum=00000000, rsp_cout=1, rsp_id=1.
- Fairness: all four requesters held valid with rsp_ready=1 → grant order 0,1,2,3,0,1 on consecutive cycles. Each rsp_id matches, and every sum is checked against the reference a+b+cin.
- Backpressure: rsp_ready=0 for 3 cycles mid-stream:
  - rsp_sum/rsp_id stay stable.
  - req_ready goes 0 after stage 1 fills.
  - No result is lost or duplicated after release.
- Chain (BK_ADD_LOCK_EN): requester 2 sends a 64-bit add in two beats:
  - Beat 1: A=FFFFFFFF, B=00000001, last=0 → sum=00000000, cout=1.
  - Beat 2: A=00000001, B=00000000, last=1 → sum=00000002, cout=0.
  - Requester 0, valid throughout, is not granted until after the last=1 beat.
- Reset mid-chain: assert rst_n=0 while LOCKED → FSM=ARB, chain carry=0, rsp_valid=0. The next add uses req_cin.

Source files
------------

// File: rtl/bk_add_pkg.sv
// Shared constants and types for the Brent-Kung adder arbiter.
// Optional chained-add locking is enabled with BK_ADD_LOCK_EN.
package bk_add_pkg;

  localparam int W_DEF    = 32;
  localparam int NREQ_DEF = 4;
  localparam int NREQ_MAX = 8;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [IDW_DEF-1:0] req_id_t;

  function automatic logic [W_DEF-1:0] opnd_slice(
    input logic [NREQ_MAX*W_DEF-1:0] bus,
    input int unsigned               k
  );
    return bus[k*W_DEF +: W_DEF];
  endfunction

endpackage

// File: rtl/Brent_Kung.sv
// Parallel-prefix (Brent-Kung) adder, carry-in folded into bit 0.
// Up-sweep builds power-of-two prefixes, down-sweep fills the rest.
module Brent_Kung #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int L = $clog2(W);

  logic [W-1:0] pp;
  logic [W-1:0] gg;
  logic [W-1:0] gp;
  logic [W-1:0] c;

  always_comb begin
    pp = a ^ b;
    gg = a & b;
    gp = pp;
    gg[0] = gg[0] | (pp[0] & cin);
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < W; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          gg[i] = gg[i] | (gp[i] & gg[i - (1 << l)]);
          gp[i] = gp[i] & gp[i - (1 << l)];
        end
      end
    end
    for (int l = L - 2; l >= 0; l--) begin
      for (int i = 0; i < W; i++) begin
        if ((i >= 3 * (1 << l) - 1) &&
            (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
          gg[i] = gg[i] | (gp[i] & gg[i - (1 << l)]);
          gp[i] = gp[i] & gp[i - (1 << l)];
        end
      end
    end
    c    = {gg[W-2:0], cin};
    s    = pp ^ c;
    cout = gg[W-1];
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Pure combinational; outputs index and one-hot grant.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic [NREQ-1:0] gnt_oh
);

  always_comb begin : pick
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid   = 1'b1;
        gnt_id      = IDW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bk_add_arbiter.sv
// Round-robin arbiter sharing one 2-stage pipelined Brent-Kung adder.
// Define BK_ADD_LOCK_EN for multi-beat chained adds with carry forwarding.
module bk_add_arbiter
  import bk_add_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0] req_cin,
  input  logic [NREQ-1:0] req_last,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_cout,
  output logic [IDW-1:0]  rsp_id
);

  logic            adv1;
  logic            adv2;
  logic            accept;
  logic [NREQ-1:0] cand;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  ptr;

  logic [NREQ_MAX*W_DEF-1:0] a_bus;
  logic [NREQ_MAX*W_DEF-1:0] b_bus;
  logic [W-1:0]    g_a;
  logic [W-1:0]    g_b;
  logic            g_cin;
  logic            g_last;

  logic            s1_valid;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic            s1_cin;
  logic [IDW-1:0]  s1_id;

  logic [W-1:0]    bk_s;
  logic            bk_cin;
  logic            bk_cout;

  assign adv2   = !rsp_valid || rsp_ready;
  assign adv1   = !s1_valid || adv2;
  assign accept = gnt_valid && adv1 && rst_n;

  assign req_ready = accept ? gnt_oh : '0;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req       (cand),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .gnt_oh    (gnt_oh)
  );

  always_comb begin
    a_bus = '0;
    b_bus = '0;
    a_bus[NREQ*W-1:0] = req_a;
    b_bus[NREQ*W-1:0] = req_b;
  end

  assign g_a   = opnd_slice(a_bus, 32'(gnt_id));
  assign g_b   = opnd_slice(b_bus, 32'(gnt_id));
  assign g_cin = req_cin[gnt_id];

`ifdef BK_ADD_LOCK_EN
  localparam logic [0:0] S_ARB  = ARB;
  localparam logic [0:0] S_LOCK = LOCKED;

  logic [0:0]      state;
  logic [IDW-1:0]  owner;
  logic [NREQ-1:0] owner_oh;
  logic            chain_c;
  logic            s1_chain;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  assign cand   = (state == S_LOCK) ? (req_valid & owner_oh) : req_valid;
  assign g_last = req_last[gnt_id];
  assign bk_cin = s1_chain ? chain_c : s1_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ARB;
      owner <= '0;
    end else if (accept) begin
      unique case (1'b1)
        (state == S_ARB) && !g_last: begin
          state <= S_LOCK;
          owner <= gnt_id;
        end
        (state == S_LOCK) && g_last: state <= S_ARB;
        default: ;
      endcase
    end
  end

  // Carry of whichever beat just left stage 1; only owner beats can be there while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_c  <= 1'b0;
      s1_chain <= 1'b0;
    end else begin
      if (adv2 && s1_valid) chain_c <= bk_cout;
      if (accept) s1_chain <= (state == S_LOCK);
    end
  end
`else
  logic unused_last;

  assign cand        = req_valid;
  assign g_last      = 1'b1;
  assign bk_cin      = s1_cin;
  assign unused_last = ^req_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && g_last) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= g_a;
        s1_b   <= g_b;
        s1_cin <= g_cin;
        s1_id  <= gnt_id;
      end
    end
  end

  Brent_Kung #(
    .W (W)
  ) u_bk (
    .a    (s1_a),
    .b    (s1_b),
    .cin  (bk_cin),
    .s    (bk_s),
    .cout (bk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (adv2) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_sum  <= bk_s;
        rsp_cout <= bk_cout;
        rsp_id   <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_bk_add_arbiter.sv
// Directed self-checking bench for bk_add_arbiter (NREQ=4, W=32).
// Chain scenarios are compiled in when BK_ADD_LOCK_EN is defined.
module tb_bk_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;

  logic [W-1:0] a_op [NREQ];
  logic [W-1:0] b_op [NREQ];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*W +: W] = a_op[k];
      req_b[k*W +: W] = b_op[k];
    end
  end

  bk_add_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_ready: got %h want 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_sum !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum);
    end
    checks++;
    if (rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_cout_id: got %b/%0d want 0/0", rsp_cout, rsp_id);
    end
    tick();
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_ready_held: got %h want 0", req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    a_op[1]    = 32'hFFFF_FFFF;
    b_op[1]    = 32'h0000_0001;
    req_cin[1] = 1'b0;
    req_valid  = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got rsp_valid %b want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0 ||
        rsp_cout !== 1'b1 || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL single_rsp: got v%b %h c%b id%0d want v1 00000000 c1 id1",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_once: got rsp_valid %b want 0", rsp_valid);
    end
  endtask

  task automatic test_fairness();
    int          exp_q[$];
    int          nresp;
    int          k;
    logic [W:0]  ref_v;
    nresp = 0;
    do_reset();
    a_op[0] = 32'hFFFF_0000; b_op[0] = 32'h0001_0000; req_cin[0] = 1'b0;
    a_op[1] = 32'h1234_5678; b_op[1] = 32'h8765_4321; req_cin[1] = 1'b1;
    a_op[2] = 32'h8000_0000; b_op[2] = 32'h8000_0000; req_cin[2] = 1'b1;
    a_op[3] = 32'h0000_0000; b_op[3] = 32'h0000_0000; req_cin[3] = 1'b0;
    req_valid = 4'hF;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) begin
        nresp++;
        k = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        ref_v = (k < 0) ? '0 :
                {1'b0, a_op[k]} + {1'b0, b_op[k]} + {32'b0, req_cin[k]};
        checks++;
        if (k < 0 || rsp_id !== IDW'(k) || {rsp_cout, rsp_sum} !== ref_v) begin
          errors++;
          $display("FAIL fair_rsp: got id%0d %b_%h want id%0d %b_%h",
                   rsp_id, rsp_cout, rsp_sum, k, ref_v[W], ref_v[W-1:0]);
        end
      end
      if (i < 6) begin
        checks++;
        if (req_ready !== 4'(1 << (i % 4))) begin
          errors++;
          $display("FAIL fair_grant%0d: got %b want %b",
                   i, req_ready, 4'(1 << (i % 4)));
        end
        exp_q.push_back(i % 4);
      end else begin
        req_valid = '0;
      end
      tick();
    end
    checks++;
    if (nresp != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fair_count: got %0d responses want 6", nresp);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_op[0] = 32'h0000_0010; b_op[0] = 32'h0000_0020; req_cin[0] = 1'b0;
    a_op[3] = 32'hFFFF_FFFF; b_op[3] = 32'hFFFF_FFFF; req_cin[3] = 1'b1;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant0: got %b want 0001", req_ready);
    end
    tick();
    a_op[0] = 32'h0000_0100;
    b_op[0] = 32'h0000_0200;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_grant3: got %b want 1000", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_stall_ready%0d: got %b want 0000", i, req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
          rsp_sum !== 32'h30 || rsp_cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v%b id%0d %h want v1 id0 00000030",
                 i, rsp_valid, rsp_id, rsp_sum);
      end
      if (i < 2) tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 ||
        rsp_sum !== 32'hFFFF_FFFF || rsp_cout !== 1'b1) begin
      errors++;
      $display("FAIL bp_rsp_b: got v%b id%0d %b_%h want v1 id3 1_ffffffff",
               rsp_valid, rsp_id, rsp_cout, rsp_sum);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h300) begin
      errors++;
      $display("FAIL bp_rsp_c: got v%b id%0d %h want v1 id0 00000300",
               rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: got rsp_valid %b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    a_op[2] = 32'h5; b_op[2] = 32'h6; req_cin[2] = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rmid_grant: got %b want 0100", req_ready);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_in_reset: got v%b ready %b want v0 ready 0000",
               rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_discard%0d: got rsp_valid %b want 0", i, rsp_valid);
      end
    end
    a_op[2] = 32'h7; b_op[2] = 32'h8; req_cin[2] = 1'b1;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h10) begin
      errors++;
      $display("FAIL rmid_after: got v%b id%0d %h want v1 id2 00000010",
               rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask

`ifdef BK_ADD_LOCK_EN
  task automatic test_chain();
    do_reset();
    a_op[1] = '0; b_op[1] = '0; req_cin[1] = 1'b0; req_last[1] = 1'b1;
    req_valid = 4'b0010;
    tick();
    a_op[2] = 32'hFFFF_FFFF; b_op[2] = 32'h1; req_cin[2] = 1'b0;
    req_last[2] = 1'b0;
    a_op[0] = 32'h3; b_op[0] = 32'h4; req_cin[0] = 1'b0; req_last[0] = 1'b1;
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL chain_beat1_grant: got %b want 0100", req_ready);
    end
    tick();
    a_op[2] = 32'h1; b_op[2] = 32'h0; req_last[2] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL chain_locked: got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL chain_unlock: got %b want 0001", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
        rsp_sum !== 32'h0 || rsp_cout !== 1'b1) begin
      errors++;
      $display("FAIL chain_rsp1: got id%0d %b_%h want id2 1_00000000",
               rsp_id, rsp_cout, rsp_sum);
    end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
        rsp_sum !== 32'h2 || rsp_cout !== 1'b0) begin
      errors++;
      $display("FAIL chain_rsp2: got id%0d %b_%h want id2 0_00000002",
               rsp_id, rsp_cout, rsp_sum);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h7) begin
      errors++;
      $display("FAIL chain_rsp_r0: got id%0d %h want id0 00000007",
               rsp_id, rsp_sum);
    end
    a_op[2] = 32'hFFFF_FFFF; b_op[2] = 32'h1; req_cin[2] = 1'b0;
    req_last[2] = 1'b0;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL chain_reset_rsp: got %b want 0", rsp_valid);
    end
    tick();
    rst_n = 1'b1;
    a_op[2] = 32'h1; b_op[2] = 32'h1; req_cin[2] = 1'b0; req_last[2] = 1'b1;
    a_op[0] = 32'h9; b_op[0] = 32'h0;
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL chain_reset_arb: got %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
        rsp_sum !== 32'h2 || rsp_cout !== 1'b0) begin
      errors++;
      $display("FAIL chain_reset_cin: got v%b id%0d %h want v1 id2 00000002",
               rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_cin   = '0;
    req_last  = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      a_op[k] = '0;
      b_op[k] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef BK_ADD_LOCK_EN
    test_chain();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
